// File: rtl/inst_issue_queue.sv
// Instruction issue queue: decodes RV32 words at entry, buffers them in a FIFO and
// presents one registered instruction per cycle to the order manager.
module inst_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             struct_haz,
    output logic             start,
    output logic [31:0]      instruction,
    output logic [2:0]       operation,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             empty,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_LW  = 3'd4,
        OP_SW  = 3'd5
    } op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } entry_t;

    // Handshakes: a push happens on in_valid && in_ready; the issued instruction is
    // taken on start && !struct_haz, and start/fields stay stable until then.

    entry_t             r_mem [DEPTH];
    entry_t             r_issue;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_start;
    logic [CNT_W-1:0]   r_issued_cnt;
    logic [CNT_W-1:0]   r_illegal_cnt;

    entry_t             w_dec;
    logic               w_dec_legal;
    logic               w_handshake;
    logic               w_push;
    logic               w_illegal;
    logic               w_accept;
    logic               w_slot_free;
    logic               w_pop;

    always_comb begin
        w_dec       = '0;
        w_dec.instr = in_instr;
        w_dec_legal = 1'b0;
        unique case (in_instr[6:0])
            7'b0110011: begin
                if (in_instr[14:12] == 3'b000) begin
                    w_dec.rs1 = in_instr[19:15];
                    w_dec.rs2 = in_instr[24:20];
                    w_dec.rd  = in_instr[11:7];
                    unique case (in_instr[31:25])
                        7'b0000000: begin w_dec.op = OP_ADD; w_dec_legal = 1'b1; end
                        7'b0100000: begin w_dec.op = OP_SUB; w_dec_legal = 1'b1; end
                        7'b0000001: begin w_dec.op = OP_MUL; w_dec_legal = 1'b1; end
                        default:    w_dec_legal = 1'b0;
                    endcase
                end
            end
            7'b0000011: begin
                if (in_instr[14:12] == 3'b010) begin
                    w_dec.op    = OP_LW;
                    w_dec.rs1   = in_instr[19:15];
                    w_dec.rd    = in_instr[11:7];
                    w_dec_legal = 1'b1;
                end
            end
            7'b0100011: begin
                if (in_instr[14:12] == 3'b010) begin
                    w_dec.op    = OP_SW;
                    w_dec.rs1   = in_instr[19:15];
                    w_dec.rs2   = in_instr[24:20];
                    w_dec_legal = 1'b1;
                end
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    // A flushed cycle discards the push, so neither storage nor the illegal count sees it.
    assign w_handshake = in_valid && in_ready && !flush;
    assign w_push      = w_handshake && w_dec_legal;
    assign w_illegal   = w_handshake && !w_dec_legal;
    assign w_accept    = r_start && !struct_haz;
    assign w_slot_free = !r_start || w_accept;
    assign w_pop       = w_slot_free && (r_count != '0) && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_start       <= 1'b0;
            r_issue       <= '0;
            r_issued_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end
            if (w_illegal) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_start  <= 1'b0;
                r_issue  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
                // The head is read from storage before this edge's write, so a push
                // into an empty FIFO always spends one cycle there before issuing.
                if (w_slot_free) begin
                    if (r_count != '0) begin
                        r_issue <= r_mem[r_rd_ptr];
                        r_start <= 1'b1;
                    end else begin
                        r_issue <= '0;
                        r_start <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready    = (r_count < FULL_COUNT);
    assign start       = r_start;
    assign instruction = r_issue.instr;
    assign operation   = r_issue.op;
    assign rs1         = r_issue.rs1;
    assign rs2         = r_issue.rs2;
    assign rd          = r_issue.rd;
    assign empty       = (r_count == '0) && !r_start;
    assign issued_cnt  = r_issued_cnt;
    assign illegal_cnt = r_illegal_cnt;

endmodule
